// File: rtl/mixcolumns_serial_if.sv
// Block-level stream bundle for mixcolumns_serial: ShiftRows-side input and
// AddRoundKey-side output, each with a valid/ready handshake.
interface mixcolumns_serial_if;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic         in_last;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/mixcolumns_serial.sv
// Column-serial AES (Inv)MixColumns: one 32-bit column per clock through a
// single shared datapath, with per-block bypass for the final round.
module mixcolumns_serial #(
  parameter bit INVERSE = 1'b0
) (
  input  logic               clk,
  input  logic               rst_n,
  mixcolumns_serial_if.slave bus
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam logic [3:0] C0 = INVERSE ? 4'he : 4'h2;
  localparam logic [3:0] C1 = INVERSE ? 4'hb : 4'h3;
  localparam logic [3:0] C2 = INVERSE ? 4'hd : 4'h1;
  localparam logic [3:0] C3 = INVERSE ? 4'h9 : 4'h1;

  state_t       state, state_next;
  logic [1:0]   col, col_next;
  logic [127:0] st, st_next;
  logic [31:0]  col_word, col_mixed;
  logic         accept;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Every coefficient used fits in 4 bits, so b*k is a sum of b, 2b, 4b, 8b.
  function automatic logic [7:0] gmul(input logic [7:0] b, input logic [3:0] k);
    logic [7:0] x2, x4, x8;
    x2 = xtime(b);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return (k[0] ? b : 8'h00) ^ (k[1] ? x2 : 8'h00) ^
           (k[2] ? x4 : 8'h00) ^ (k[3] ? x8 : 8'h00);
  endfunction

  function automatic logic [31:0] mix_word(input logic [31:0] w);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = w;
    return {gmul(a0, C0) ^ gmul(a1, C1) ^ gmul(a2, C2) ^ gmul(a3, C3),
            gmul(a0, C3) ^ gmul(a1, C0) ^ gmul(a2, C1) ^ gmul(a3, C2),
            gmul(a0, C2) ^ gmul(a1, C3) ^ gmul(a2, C0) ^ gmul(a3, C1),
            gmul(a0, C1) ^ gmul(a1, C2) ^ gmul(a2, C3) ^ gmul(a3, C0)};
  endfunction

  // A completed block in DONE may be released and replaced in the same cycle.
  assign bus.in_ready  = (state == IDLE) | ((state == DONE) & bus.out_ready);
  assign bus.out_valid = (state == DONE);
  assign bus.out_data  = st;
  assign accept        = bus.in_valid & bus.in_ready;

  always_comb begin
    col_word = st[127:96];
    case (col)
      2'd0:    col_word = st[127:96];
      2'd1:    col_word = st[95:64];
      2'd2:    col_word = st[63:32];
      default: col_word = st[31:0];
    endcase
  end

  assign col_mixed = mix_word(col_word);

  always_comb begin
    state_next = state;
    col_next   = col;
    st_next    = st;
    case (state)
      BUSY: begin
        case (col)
          2'd0:    st_next[127:96] = col_mixed;
          2'd1:    st_next[95:64]  = col_mixed;
          2'd2:    st_next[63:32]  = col_mixed;
          default: st_next[31:0]   = col_mixed;
        endcase
        col_next = col + 2'd1;
        if (col == 2'd3) state_next = DONE;
      end
      DONE: begin
        if (bus.out_ready) state_next = IDLE;
      end
      default: ;
    endcase
    if (accept) begin
      st_next    = bus.in_data;
      col_next   = 2'd0;
      state_next = bus.in_last ? DONE : BUSY;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      col   <= 2'd0;
      st    <= '0;
    end else begin
      state <= state_next;
      col   <= col_next;
      st    <= st_next;
    end
  end

endmodule
